mem_access_ctrl: RTL and testbench

- MEM-stage controller that produces the values the MEM/WB pipeline register captures.
- Sits between the EX/MEM register outputs and the MEM/WB register inputs.
- Runs load/store accesses to a variable-latency data memory over a req/ack handshake.
- Stalls the front of the pipeline while an access is outstanding, inserts write-back bubbles, and aborts accesses that are misaligned or time out.

---
 rtl/mem_access_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Purpose:
//   MEM-stage controller placed between the EX/MEM and MEM/WB pipeline
//   registers. Instructions that do not touch memory pass straight through
//   with zero latency. Loads and stores are run against a variable-latency
//   data memory over a req/ack handshake. While an access is outstanding the
//   front of the pipeline is stalled and write-back bubbles are inserted.
//   Misaligned accesses and accesses that exceed TIMEOUT cycles are aborted
//   and flagged with a one-cycle err_o pulse.
//
// Parameters:
//   TIMEOUT      ACCESS cycles without mem_ack_i before the access is aborted
//                (2..255).
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active low
//   MemRead_i    load request from EX/MEM
//   MemWrite_i   store request from EX/MEM (wins when both are set)
//   MemtoReg_i   write-back select from EX/MEM
//   RegWrite_i   write-back enable from EX/MEM
//   ALUResult_i  ALU result, also the memory byte address
//   WriteData_i  store data
//   RegAddr_i    destination register
//   mem_req_o    memory request, held until acknowledged or aborted
//   mem_we_o     1 = store, 0 = load
//   mem_addr_o   word-aligned byte address
//   mem_wdata_o  store data
//   mem_ack_i    one-cycle completion strobe from memory
//   mem_rdata_i  load data, valid with mem_ack_i
//   stall_o      freezes PC, IF/ID, ID/EX and holds EX/MEM
//   err_o        one-cycle pulse flagging an aborted access
//   MemtoReg_o   to MEM/WB
//   RegWrite_o   to MEM/WB
//   ALUResult_o  to MEM/WB
//   MemData_o    to MEM/WB
//   RegAddr_o    to MEM/WB
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        MemtoReg_i,
    input  logic        RegWrite_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] WriteData_i,
    input  logic [4:0]  RegAddr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic        err_o,
    output logic        MemtoReg_o,
    output logic        RegWrite_o,
    output logic [31:0] ALUResult_o,
    output logic [31:0] MemData_o,
    output logic [4:0]  RegAddr_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Last counter value at which a missing ack still keeps the access alive.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_memReq;
    logic        r_memWe;
    logic [31:0] r_memAddr;
    logic [31:0] r_memWdata;
    logic [31:0] r_rdata;
    logic [7:0]  r_count;
    logic        r_err;

    logic        w_access;
    logic        w_aligned;
    logic        w_stall;
    logic        w_regWrite;
    logic [31:0] w_memData;

    assign w_access  = MemRead_i | MemWrite_i;
    assign w_aligned = (ALUResult_i[1:0] == 2'b00);

    // Access sequencer. The request signals are launched from IDLE and held
    // unchanged through ACCESS; EX/MEM is frozen by the stall, so nothing is
    // re-sampled there. DONE always lasts exactly one cycle so the next
    // instruction gets a fresh evaluation in IDLE. r_err is only ever set on
    // the edge into DONE and cleared on the edge out, which makes it directly
    // usable as the err_o pulse.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= S_IDLE;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_rdata    <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        if (w_aligned) begin
                            r_state    <= S_ACCESS;
                            r_memReq   <= 1'b1;
                            r_memWe    <= MemWrite_i;
                            r_memAddr  <= ALUResult_i;
                            r_memWdata <= WriteData_i;
                            r_count    <= '0;
                        end else begin
                            r_state <= S_DONE;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    // Ack is tested first so it wins over a simultaneous timeout.
                    if (mem_ack_i) begin
                        r_rdata  <= r_memWe ? 32'd0 : mem_rdata_i;
                        r_memReq <= 1'b0;
                        r_state  <= S_DONE;
                    end else if (r_count == TO_LAST) begin
                        r_memReq <= 1'b0;
                        r_err    <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Pipeline-side outputs. A memory instruction is held as a bubble
    // (RegWrite suppressed) from the moment it is detected until DONE, where
    // it is released with the captured data, or squashed if it was aborted.
    // Stall and RegWrite are forced low for the whole reset assertion so a
    // reset mid-access releases the pipeline immediately.
    always_comb begin
        w_stall    = 1'b0;
        w_regWrite = RegWrite_i;
        w_memData  = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    w_stall    = 1'b1;
                    w_regWrite = 1'b0;
                end
            end
            S_ACCESS: begin
                w_stall    = 1'b1;
                w_regWrite = 1'b0;
            end
            S_DONE: begin
                if (r_err) begin
                    w_regWrite = 1'b0;
                end else begin
                    w_memData = r_rdata;
                end
            end
            default: begin
                w_stall    = 1'b0;
                w_regWrite = 1'b0;
            end
        endcase
        if (!rst_i) begin
            w_stall    = 1'b0;
            w_regWrite = 1'b0;
        end
    end

    assign mem_req_o   = r_memReq;
    assign mem_we_o    = r_memWe;
    assign mem_addr_o  = r_memAddr;
    assign mem_wdata_o = r_memWdata;
    assign err_o       = r_err;

    assign stall_o     = w_stall;
    assign RegWrite_o  = w_regWrite;
    assign MemData_o   = w_memData;
    assign MemtoReg_o  = MemtoReg_i;
    assign ALUResult_o = ALUResult_i;
    assign RegAddr_o   = RegAddr_i;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Purpose:
//   Self-checking bench for mem_access_ctrl. A table of per-cycle records
//   drives the single-cycle and short multi-cycle cases; hand-written
//   sequences cover reset values, timeout, ack-on-timeout and reset during
//   an outstanding access.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int unsigned TIMEOUT = 16;
    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;
    localparam logic [31:0] JUNK = 32'hBAD0BAD0;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic        MemtoReg_i;
    logic        RegWrite_i;
    logic [31:0] ALUResult_i;
    logic [31:0] WriteData_i;
    logic [4:0]  RegAddr_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic        err_o;
    logic        MemtoReg_o;
    logic        RegWrite_o;
    logic [31:0] ALUResult_o;
    logic [31:0] MemData_o;
    logic [4:0]  RegAddr_o;

    int total = 0;
    int bad   = 0;

    // One record per clock cycle: inputs applied, then outputs expected in
    // that same cycle.
    typedef struct {
        logic        rd;
        logic        wr;
        logic        m2r;
        logic        rw;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic        ack;
        logic [31:0] rdata;
        logic        eStall;
        logic        eReq;
        logic        eWe;
        logic        eErr;
        logic        eRw;
        logic        eM2r;
        logic [31:0] eMemData;
        logic        chkMem;
        logic [31:0] eAddr;
        logic [31:0] eWdata;
    } vec_t;

    vec_t vecs[$];

    mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .MemtoReg_i  (MemtoReg_i),
        .RegWrite_i  (RegWrite_i),
        .ALUResult_i (ALUResult_i),
        .WriteData_i (WriteData_i),
        .RegAddr_i   (RegAddr_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_o     (stall_o),
        .err_o       (err_o),
        .MemtoReg_o  (MemtoReg_o),
        .RegWrite_o  (RegWrite_o),
        .ALUResult_o (ALUResult_o),
        .MemData_o   (MemData_o),
        .RegAddr_o   (RegAddr_o)
    );

    // Free-running 10-unit clock.
    always #5 clk_i = ~clk_i;

    // Absolute safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #2;
    endtask

    task automatic setInputs(input logic rd, input logic wr, input logic m2r, input logic rw,
                             input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] ra);
        MemRead_i   = rd;
        MemWrite_i  = wr;
        MemtoReg_i  = m2r;
        RegWrite_i  = rw;
        ALUResult_i = alu;
        WriteData_i = wd;
        RegAddr_i   = ra;
    endtask

    task automatic applyStimulus(input vec_t v);
        setInputs(v.rd, v.wr, v.m2r, v.rw, v.alu, v.wd, v.ra);
        mem_ack_i   = v.ack;
        mem_rdata_i = v.rdata;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        chk($sformatf("row%0d.stall", idx),   32'(stall_o),    32'(v.eStall));
        chk($sformatf("row%0d.req", idx),     32'(mem_req_o),  32'(v.eReq));
        chk($sformatf("row%0d.err", idx),     32'(err_o),      32'(v.eErr));
        chk($sformatf("row%0d.regWrite", idx), 32'(RegWrite_o), 32'(v.eRw));
        chk($sformatf("row%0d.memData", idx), MemData_o,       v.eMemData);
        if (v.chkMem) begin
            chk($sformatf("row%0d.we", idx),    32'(mem_we_o), 32'(v.eWe));
            chk($sformatf("row%0d.addr", idx),  mem_addr_o,    v.eAddr);
            chk($sformatf("row%0d.wdata", idx), mem_wdata_o,   v.eWdata);
        end
        if (!v.eStall) begin
            chk($sformatf("row%0d.aluRes", idx),   ALUResult_o,     v.alu);
            chk($sformatf("row%0d.regAddr", idx),  32'(RegAddr_o),  32'(v.ra));
            chk($sformatf("row%0d.memtoReg", idx), 32'(MemtoReg_o), 32'(v.eM2r));
        end
    endtask

    initial begin
        int reqCycles;

        // ALU op with a stray ack that must be ignored outside ACCESS.
        vecs.push_back('{N,N,N,Y,32'h1234,32'h0,5'd5,Y,JUNK,       N,N,N,N,Y,N,32'h0,N,32'h0,32'h0});
        // Load 0x40, acked 3 cycles after the request rises.
        vecs.push_back('{Y,N,Y,Y,32'h40,32'h11111111,5'd7,N,JUNK,  Y,N,N,N,N,Y,32'h0,N,32'h0,32'h0});
        vecs.push_back('{Y,N,Y,Y,32'h40,32'h11111111,5'd7,N,JUNK,  Y,Y,N,N,N,Y,32'h0,Y,32'h40,32'h11111111});
        vecs.push_back('{Y,N,Y,Y,32'h40,32'h11111111,5'd7,N,JUNK,  Y,Y,N,N,N,Y,32'h0,Y,32'h40,32'h11111111});
        vecs.push_back('{Y,N,Y,Y,32'h40,32'h11111111,5'd7,N,JUNK,  Y,Y,N,N,N,Y,32'h0,Y,32'h40,32'h11111111});
        vecs.push_back('{Y,N,Y,Y,32'h40,32'h11111111,5'd7,Y,32'hDEADBEEF, Y,Y,N,N,N,Y,32'h0,Y,32'h40,32'h11111111});
        vecs.push_back('{Y,N,Y,Y,32'h40,32'h11111111,5'd7,N,JUNK,  N,N,N,N,Y,Y,32'hDEADBEEF,N,32'h0,32'h0});
        vecs.push_back('{N,N,N,Y,32'h2000,32'h0,5'd6,N,JUNK,       N,N,N,N,Y,N,32'h0,N,32'h0,32'h0});
        // Store 0x80, acked in the first request cycle; read data must not leak.
        vecs.push_back('{N,Y,N,N,32'h80,32'hA5A5A5A5,5'd0,N,JUNK,  Y,N,N,N,N,N,32'h0,N,32'h0,32'h0});
        vecs.push_back('{N,Y,N,N,32'h80,32'hA5A5A5A5,5'd0,Y,32'hFFFFFFFF, Y,Y,Y,N,N,N,32'h0,Y,32'h80,32'hA5A5A5A5});
        vecs.push_back('{N,Y,N,N,32'h80,32'hA5A5A5A5,5'd0,N,JUNK,  N,N,N,N,N,N,32'h0,N,32'h0,32'h0});
        // Misaligned load 0x42: no request, one stall cycle, error DONE.
        vecs.push_back('{Y,N,Y,Y,32'h42,32'h0,5'd3,N,JUNK,         Y,N,N,N,N,Y,32'h0,N,32'h0,32'h0});
        vecs.push_back('{Y,N,Y,Y,32'h42,32'h0,5'd3,N,JUNK,         N,N,N,Y,N,Y,32'h0,N,32'h0,32'h0});
        vecs.push_back('{N,N,N,Y,32'h3000,32'h0,5'd4,N,JUNK,       N,N,N,N,Y,N,32'h0,N,32'h0,32'h0});
        // MemRead and MemWrite both set: treated as a store.
        vecs.push_back('{Y,Y,N,Y,32'hC0,32'h0F0F0F0F,5'd8,N,JUNK,  Y,N,N,N,N,N,32'h0,N,32'h0,32'h0});
        vecs.push_back('{Y,Y,N,Y,32'hC0,32'h0F0F0F0F,5'd8,Y,32'h12345678, Y,Y,Y,N,N,N,32'h0,Y,32'hC0,32'h0F0F0F0F});
        vecs.push_back('{Y,Y,N,Y,32'hC0,32'h0F0F0F0F,5'd8,N,JUNK,  N,N,N,N,Y,N,32'h0,N,32'h0,32'h0});
        vecs.push_back('{N,N,N,Y,32'h4000,32'h0,5'd9,N,JUNK,       N,N,N,N,Y,N,32'h0,N,32'h0,32'h0});

        // Reset values, with a pending aligned load on the inputs.
        rst_i = 1'b0;
        setInputs(Y, N, Y, Y, 32'h40, 32'h77777777, 5'd2);
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        #3;
        chk("reset.stall",    32'(stall_o),    32'd0);
        chk("reset.regWrite", 32'(RegWrite_o), 32'd0);
        chk("reset.req",      32'(mem_req_o),  32'd0);
        chk("reset.we",       32'(mem_we_o),   32'd0);
        chk("reset.addr",     mem_addr_o,      32'd0);
        chk("reset.wdata",    mem_wdata_o,     32'd0);
        chk("reset.err",      32'(err_o),      32'd0);
        chk("reset.memData",  MemData_o,       32'd0);
        setInputs(N, N, N, N, 32'h0, 32'h0, 5'd0);
        #9;
        rst_i = 1'b1;
        nextCycle();

        // Table-driven vectors, one record per cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk_i);
            checkOutput(vecs[i], i);
            nextCycle();
        end

        // Timeout: no ack at all, request must stay high exactly TIMEOUT cycles.
        mem_ack_i = 1'b0;
        mem_rdata_i = JUNK;
        setInputs(Y, N, Y, Y, 32'h100, 32'h0, 5'd9);
        @(negedge clk_i);
        chk("timeout.idleStall", 32'(stall_o), 32'd1);
        nextCycle();
        reqCycles = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (!mem_req_o) break;
            reqCycles++;
            nextCycle();
        end
        chk("timeout.reqCycles", 32'(reqCycles),  32'(TIMEOUT));
        chk("timeout.err",       32'(err_o),      32'd1);
        chk("timeout.regWrite",  32'(RegWrite_o), 32'd0);
        chk("timeout.stall",     32'(stall_o),    32'd0);
        chk("timeout.memData",   MemData_o,       32'd0);
        nextCycle();
        setInputs(N, N, N, Y, 32'h5000, 32'h0, 5'd10);
        @(negedge clk_i);
        chk("timeout.errCleared", 32'(err_o), 32'd0);
        nextCycle();

        // Ack arriving in the last allowed cycle wins over the timeout.
        setInputs(Y, N, Y, Y, 32'h104, 32'h0, 5'd11);
        @(negedge clk_i);
        nextCycle();
        reqCycles = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (!mem_req_o) break;
            reqCycles++;
            if (reqCycles == int'(TIMEOUT)) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = 32'hCAFEF00D;
            end
            nextCycle();
            mem_ack_i   = 1'b0;
            mem_rdata_i = JUNK;
        end
        chk("lateAck.reqCycles", 32'(reqCycles),  32'(TIMEOUT));
        chk("lateAck.err",       32'(err_o),      32'd0);
        chk("lateAck.regWrite",  32'(RegWrite_o), 32'd1);
        chk("lateAck.memData",   MemData_o,       32'hCAFEF00D);
        chk("lateAck.regAddr",   32'(RegAddr_o),  32'd11);
        nextCycle();
        setInputs(N, N, N, N, 32'h0, 32'h0, 5'd0);
        nextCycle();

        // Reset asserted in the second ACCESS cycle.
        setInputs(Y, N, Y, Y, 32'h200, 32'h0, 5'd12);
        @(negedge clk_i);
        chk("rstMid.idleStall", 32'(stall_o), 32'd1);
        nextCycle();
        @(negedge clk_i);
        chk("rstMid.req1", 32'(mem_req_o), 32'd1);
        nextCycle();
        rst_i = 1'b0;
        #1;
        chk("rstMid.req",      32'(mem_req_o),  32'd0);
        chk("rstMid.stall",    32'(stall_o),    32'd0);
        chk("rstMid.regWrite", 32'(RegWrite_o), 32'd0);
        setInputs(N, N, N, Y, 32'h5555, 32'h0, 5'd13);
        @(negedge clk_i);
        rst_i = 1'b1;
        nextCycle();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hBADBAD00;
        @(negedge clk_i);
        chk("rstMid.ackStall",   32'(stall_o),    32'd0);
        chk("rstMid.ackReq",     32'(mem_req_o),  32'd0);
        chk("rstMid.passRw",     32'(RegWrite_o), 32'd1);
        chk("rstMid.passAlu",    ALUResult_o,     32'h5555);
        chk("rstMid.memData",    MemData_o,       32'd0);
        nextCycle();
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        @(negedge clk_i);
        chk("rstMid.afterReq",   32'(mem_req_o), 32'd0);
        chk("rstMid.afterErr",   32'(err_o),     32'd0);
        chk("rstMid.afterStall", 32'(stall_o),   32'd0);
        chk("rstMid.afterData",  MemData_o,      32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
